z80_cb_shift_unit: RTL and testbench

//   Execution unit for CB-prefixed rotate/shift instructions: RLC RRC RL RR SLA SRA SLL SRL, on r or (HL).

---
 rtl/z80_cb_shift_unit_pkg.sv | 45 ++++
 rtl/z80_cb_shift_unit_alu.sv | 40 ++++
 rtl/z80_cb_shift_unit.sv | 136 +++++++++++++
 tb/tb_z80_cb_shift_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_cb_shift_unit_pkg.sv
// Shared Z80 definitions for the CB rotate/shift unit: register indices,
// flag bit positions, shift op codes and the parity helper.
package z80_cb_shift_unit_pkg;

   localparam logic [2:0] REG_B      = 3'd0;
   localparam logic [2:0] REG_C      = 3'd1;
   localparam logic [2:0] REG_D      = 3'd2;
   localparam logic [2:0] REG_E      = 3'd3;
   localparam logic [2:0] REG_H      = 3'd4;
   localparam logic [2:0] REG_L      = 3'd5;
   localparam logic [2:0] REG_HL_IND = 3'd6;
   localparam logic [2:0] REG_A      = 3'd7;

   localparam int FLAG_C_NUM  = 0;
   localparam int FLAG_N_NUM  = 1;
   localparam int FLAG_PV_NUM = 2;
   localparam int FLAG_3_NUM  = 3;
   localparam int FLAG_H_NUM  = 4;
   localparam int FLAG_5_NUM  = 5;
   localparam int FLAG_Z_NUM  = 6;
   localparam int FLAG_S_NUM  = 7;

   localparam logic [2:0] SHIFT_OP_RLC = 3'd0;
   localparam logic [2:0] SHIFT_OP_RRC = 3'd1;
   localparam logic [2:0] SHIFT_OP_RL  = 3'd2;
   localparam logic [2:0] SHIFT_OP_RR  = 3'd3;
   localparam logic [2:0] SHIFT_OP_SLA = 3'd4;
   localparam logic [2:0] SHIFT_OP_SRA = 3'd5;
   localparam logic [2:0] SHIFT_OP_SLL = 3'd6;
   localparam logic [2:0] SHIFT_OP_SRL = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_EXEC   = 3'd1,
      ST_MEM_RD = 3'd2,
      ST_MEM_WR = 3'd3,
      ST_DONE   = 3'd4
   } cb_state_t;

   // 1 when the byte has an even number of set bits (Z80 PV after shifts)
   function automatic logic parity8(input logic [7:0] d);
      return ~(^d);
   endfunction

endpackage

// File: rtl/z80_cb_shift_unit_alu.sv
// Combinational rotate/shift datapath with Z80 flag generation; also usable
// standalone by instruction-level checkers.
module z80_shift_alu
   import z80_cb_shift_unit_pkg::*;
(
   input  logic [2:0] op,
   input  logic [7:0] din,
   input  logic [7:0] f_in,
   output logic [7:0] dout,
   output logic [7:0] fout
);

   logic carry;

   always_comb begin
      dout  = '0;
      carry = 1'b0;
      case (op)
         SHIFT_OP_RLC: begin dout = {din[6:0], din[7]};  carry = din[7]; end
         SHIFT_OP_RRC: begin dout = {din[0], din[7:1]};  carry = din[0]; end
         SHIFT_OP_RL:  begin dout = {din[6:0], f_in[0]}; carry = din[7]; end
         SHIFT_OP_RR:  begin dout = {f_in[0], din[7:1]}; carry = din[0]; end
         SHIFT_OP_SLA: begin dout = {din[6:0], 1'b0};    carry = din[7]; end
         SHIFT_OP_SRA: begin dout = {din[7], din[7:1]};  carry = din[0]; end
         SHIFT_OP_SLL: begin dout = {din[6:0], 1'b1};    carry = din[7]; end
         default:      begin dout = {1'b0, din[7:1]};    carry = din[0]; end
      endcase

      fout              = '0;
      fout[FLAG_S_NUM]  = dout[7];
      fout[FLAG_Z_NUM]  = (dout == 8'h00);
      fout[FLAG_5_NUM]  = f_in[FLAG_5_NUM];
      fout[FLAG_H_NUM]  = 1'b0;
      fout[FLAG_3_NUM]  = f_in[FLAG_3_NUM];
      fout[FLAG_PV_NUM] = parity8(dout);
      fout[FLAG_N_NUM]  = 1'b0;
      fout[FLAG_C_NUM]  = carry;
   end

endmodule

// File: rtl/z80_cb_shift_unit.sv
// Sequencer for CB rotate/shift instructions: register form in one execute
// cycle, (HL) form as a read-modify-write bus sequence.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | waiting for start; latches opcode, HL, F on start
//   ST_EXEC   | register operand on reg_rdata, result captured
//   ST_MEM_RD | bus read at HL, held until mem_ready
//   ST_MEM_WR | bus write of result at HL, held until mem_ready
//   ST_DONE   | one-cycle retire: done plus register/flag write strobes
module z80_cb_shift_unit
   import z80_cb_shift_unit_pkg::*;
#(
   parameter bit STRICT = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  opcode,
   output logic [2:0]  reg_sel,
   input  logic [7:0]  reg_rdata,
   input  logic [7:0]  f_in,
   input  logic [15:0] hl_in,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic        reg_we,
   output logic [2:0]  reg_widx,
   output logic [7:0]  reg_wdata,
   output logic        f_we,
   output logic [7:0]  f_out,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_rdata,
   output logic        mem_wr,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ready
);

   cb_state_t   state_q, state_d;
   logic [2:0]  op_q;
   logic [2:0]  r_q;
   logic [15:0] hl_q;
   logic [7:0]  f_q;
   logic        illegal_q;
   logic [7:0]  result_q;
   logic [7:0]  flags_q;
   logic        reject;
   logic [7:0]  alu_din;
   logic [7:0]  alu_dout;
   logic [7:0]  alu_fout;

   assign reject  = (opcode[7:6] != 2'b00) || (STRICT && (opcode[5:3] == SHIFT_OP_SLL));
   assign alu_din = (state_q == ST_MEM_RD) ? mem_rdata : reg_rdata;

   z80_shift_alu u_alu (
      .op   (op_q),
      .din  (alu_din),
      .f_in (f_q),
      .dout (alu_dout),
      .fout (alu_fout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         op_q      <= '0;
         r_q       <= '0;
         hl_q      <= '0;
         f_q       <= '0;
         illegal_q <= 1'b0;
         result_q  <= '0;
         flags_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  op_q      <= opcode[5:3];
                  r_q       <= opcode[2:0];
                  hl_q      <= hl_in;
                  f_q       <= f_in;
                  illegal_q <= reject;
                  result_q  <= '0;
                  flags_q   <= '0;
               end
            end
            ST_EXEC: begin
               result_q <= alu_dout;
               flags_q  <= alu_fout;
            end
            ST_MEM_RD: begin
               if (mem_ready) begin
                  result_q <= alu_dout;
                  flags_q  <= alu_fout;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (reject)                       state_d = ST_DONE;
               else if (opcode[2:0] == REG_HL_IND) state_d = ST_MEM_RD;
               else                              state_d = ST_EXEC;
            end
         end
         ST_EXEC:   state_d = ST_DONE;
         ST_MEM_RD: if (mem_ready) state_d = ST_MEM_WR;
         ST_MEM_WR: if (mem_ready) state_d = ST_DONE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != ST_IDLE);
      done      = (state_q == ST_DONE);
      illegal   = done && illegal_q;
      reg_we    = done && !illegal_q && (r_q != REG_HL_IND);
      f_we      = done && !illegal_q;
      mem_rd    = (state_q == ST_MEM_RD);
      mem_wr    = (state_q == ST_MEM_WR);
      mem_addr  = (mem_rd || mem_wr) ? hl_q : 16'h0000;
      mem_wdata = mem_wr ? result_q : 8'h00;
      reg_sel   = r_q;
      reg_widx  = r_q;
      reg_wdata = result_q;
      f_out     = flags_q;
   end

endmodule

// File: tb/tb_z80_cb_shift_unit.sv
// Scoreboard bench for the CB rotate/shift unit: driver pushes expected
// retire and bus-write records, monitors pop and compare as the DUT presents them.
module tb_z80_cb_shift_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  opcode;
   logic [2:0]  reg_sel;
   logic [7:0]  reg_rdata;
   logic [7:0]  f_in;
   logic [15:0] hl_in;
   logic        busy, done, illegal, reg_we, f_we, mem_rd, mem_wr;
   logic [2:0]  reg_widx;
   logic [7:0]  reg_wdata, f_out, mem_rdata, mem_wdata;
   logic [15:0] mem_addr;
   logic        mem_ready;

   logic [7:0]  regs [8];
   logic [7:0]  mem_val;
   int          wait_states, wait_cnt;
   logic [15:0] cur_hl;
   int          rd_cnt, wr_cnt;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [7:0]  last_wdata, last_fout;

   typedef struct {
      bit         ill;
      bit         rwe;
      bit         fwe;
      logic [2:0] widx;
      logic [7:0] wdata;
      logic [7:0] fout;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  wr_q[$];

   always #5 clk = ~clk;

   assign reg_rdata = regs[reg_sel];
   assign mem_rdata = mem_rd ? mem_val : 8'h5A;

   z80_cb_shift_unit #(.STRICT(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode),
      .reg_sel(reg_sel), .reg_rdata(reg_rdata), .f_in(f_in), .hl_in(hl_in),
      .busy(busy), .done(done), .illegal(illegal), .reg_we(reg_we),
      .reg_widx(reg_widx), .reg_wdata(reg_wdata), .f_we(f_we), .f_out(f_out),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
      .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_ready(mem_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: arithmetic shift with a chosen fill bit, flags from the result.
   function automatic void model(input int op, input int din, input int f,
                                 output logic [7:0] dout, output logic [7:0] fo);
      int fill, cy, outv;
      logic [7:0] ob;
      if (op % 2 == 0) begin
         cy = din / 128;
         case (op)
            0: fill = cy;
            2: fill = f % 2;
            4: fill = 0;
            default: fill = 1;
         endcase
         outv = (din * 2) % 256 + fill;
      end else begin
         cy = din % 2;
         case (op)
            1: fill = cy;
            3: fill = f % 2;
            5: fill = din / 128;
            default: fill = 0;
         endcase
         outv = din / 2 + 128 * fill;
      end
      ob   = 8'(outv);
      dout = ob;
      fo   = 8'((outv >= 128 ? 128 : 0) + (outv == 0 ? 64 : 0) + (f & 'h28)
               + (($countones(ob) % 2 == 0) ? 4 : 0) + cy);
   endfunction

   // Memory responder: ready after wait_states idle cycles of each bus request.
   initial begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
      forever begin
         @(negedge clk);
         mem_ready = 1'b0;
         if (mem_rd || mem_wr) begin
            if (wait_cnt >= wait_states) begin
               mem_ready = 1'b1;
               wait_cnt  = 0;
            end else wait_cnt++;
         end else wait_cnt = 0;
      end
   end

   // Monitor: bus rules and retire scoreboard.
   always @(negedge clk) begin
      if (mem_rd || mem_wr) begin
         chk("rd_wr_exclusive", {31'b0, mem_rd && mem_wr}, 32'd0);
         chk("mem_addr", {16'b0, mem_addr}, {16'b0, cur_hl});
      end
      if (mem_rd) rd_cnt++;
      if (mem_wr) begin
         wr_cnt++;
         if (mem_ready) begin
            if (wr_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
            else chk("mem_wdata", {24'b0, mem_wdata}, {24'b0, wr_q.pop_front()});
         end
      end
      if (done) begin
         if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
            chk("reg_we", {31'b0, reg_we}, {31'b0, e.rwe});
            chk("f_we", {31'b0, f_we}, {31'b0, e.fwe});
            if (e.rwe) begin
               chk("reg_widx", {29'b0, reg_widx}, {29'b0, e.widx});
               chk("reg_wdata", {24'b0, reg_wdata}, {24'b0, e.wdata});
            end
            if (e.fwe) chk("f_out", {24'b0, f_out}, {24'b0, e.fout});
            last_wdata = reg_wdata;
            last_fout  = f_out;
         end
      end
   end

   task automatic setup_op(input logic [7:0] opc, input logic [7:0] rval, input logic [7:0] f,
                           input logic [15:0] hl, input logic [7:0] mval, input int waits,
                           output bit ill, output bit hlf);
      exp_t e;
      logic [7:0] d, fo;
      ill = (opc[7:6] != 2'b00) || (opc[5:3] == 3'd6);
      hlf = (opc[2:0] == 3'd6);
      model(int'(opc[5:3]), hlf ? int'(mval) : int'(rval), int'(f), d, fo);
      e.ill = ill; e.rwe = !ill && !hlf; e.fwe = !ill;
      e.widx = opc[2:0]; e.wdata = d; e.fout = fo;
      exp_q.push_back(e);
      if (!ill && hlf) wr_q.push_back(d);
      for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
      regs[opc[2:0]] = rval;
      f_in = f; hl_in = hl; mem_val = mval; wait_states = waits; cur_hl = hl;
      rd_cnt = 0; wr_cnt = 0;
   endtask

   task automatic run_op(input logic [7:0] opc, input logic [7:0] rval, input logic [7:0] f,
                         input logic [15:0] hl, input logic [7:0] mval, input int waits,
                         input bit poke_busy);
      bit ill, hlf;
      int lat, exp_lat;
      setup_op(opc, rval, f, hl, mval, waits, ill, hlf);
      @(negedge clk);
      start = 1'b1; opcode = opc;
      @(negedge clk);
      start = 1'b0; lat = 1;
      f_in = 8'($urandom); hl_in = 16'($urandom);
      while (!done && lat < 60) begin
         if (poke_busy && lat == 1) begin start = 1'b1; opcode = 8'($urandom); end
         @(negedge clk);
         start = 1'b0;
         lat++;
      end
      exp_lat = ill ? 1 : (hlf ? 3 + 2 * waits : 2);
      chk("latency", lat, exp_lat);
      if (!done && exp_q.size() > 0) begin
         void'(exp_q.pop_back());
         if (!ill && hlf && wr_q.size() > 0) void'(wr_q.pop_back());
      end
      chk("rd_cycles", rd_cnt, (hlf && !ill) ? waits + 1 : 0);
      chk("wr_cycles", wr_cnt, (hlf && !ill) ? waits + 1 : 0);
      @(negedge clk);
      chk("idle_after_done", {30'b0, busy, done}, 32'd0);
   endtask

   initial begin
      bit ill, hlf;
      int guard;
      reset = 1'b1; start = 1'b0; opcode = 8'h00;
      f_in = 8'h00; hl_in = 16'h0000; mem_val = 8'h00; wait_states = 0;
      cur_hl = 16'h0000; rd_cnt = 0; wr_cnt = 0;
      for (int i = 0; i < 8; i++) regs[i] = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_strobes", {25'b0, busy, done, illegal, reg_we, f_we, mem_rd, mem_wr}, 32'd0);
      chk("rst_data", {reg_wdata, f_out, mem_wdata, 5'b0, reg_widx}, 32'd0);
      chk("rst_addr", {16'b0, mem_addr}, 32'd0);
      reset = 1'b0;

      run_op(8'h28, 8'h85, 8'h00, 16'h1234, 8'h00, 0, 1'b0);
      chk("sra_b_wdata", {24'b0, last_wdata}, 32'hC2);
      chk("sra_b_fout", {24'b0, last_fout}, 32'h81);
      run_op(8'h3F, 8'h01, 8'h28, 16'h0000, 8'h00, 0, 1'b0);
      chk("srl_a_wdata", {24'b0, last_wdata}, 32'h00);
      chk("srl_a_fout", {24'b0, last_fout}, 32'h6D);
      run_op(8'h11, 8'h80, 8'h01, 16'h0000, 8'h00, 0, 1'b1);
      chk("rl_c_wdata", {24'b0, last_wdata}, 32'h01);
      chk("rl_c_fout", {24'b0, last_fout}, 32'h01);
      run_op(8'h26, 8'h00, 8'h00, 16'h4000, 8'h81, 2, 1'b1);
      chk("sla_hl_fout", {24'b0, last_fout}, 32'h01);
      run_op(8'h30, 8'h55, 8'h00, 16'h0000, 8'h00, 0, 1'b0);
      run_op(8'hC6, 8'h55, 8'hFF, 16'h2222, 8'h11, 1, 1'b0);

      // Reset while the (HL) write is waiting for mem_ready.
      setup_op(8'h26, 8'h00, 8'h00, 16'h4000, 8'h81, 2, ill, hlf);
      @(negedge clk); start = 1'b1; opcode = 8'h26;
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1; opcode = 8'h00;
      @(negedge clk); start = 1'b0;
      guard = 0;
      while (!mem_wr && guard < 20) begin @(negedge clk); guard++; end
      chk("reached_mem_wr", {31'b0, mem_wr}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_state", {26'b0, busy, done, reg_we, f_we, mem_rd, mem_wr}, 32'd0);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      if (wr_q.size() > 0) void'(wr_q.pop_back());
      repeat (4) @(negedge clk);
      chk("abort_quiet", {30'b0, busy, done}, 32'd0);

      for (int n = 0; n < 60; n++) begin
         logic [7:0] opc;
         opc = {($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                3'($urandom), 3'($urandom)};
         run_op(opc, 8'($urandom), 8'($urandom), 16'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom));
      end

      repeat (3) @(negedge clk);
      chk("queues_drained", exp_q.size() + wr_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
